fp_addsub_pipe: RTL
===================

Name: fp_addsub_pipe

Overview:
Parametrised, pipelined floating-point adder/subtractor. It generalises the fixed single-precision fpadd to any exponent/mantissa width, adds per-operation add/sub select and a ready/valid output handshake with backpressure. It sits in the VGG16 datapath between the FP multiplier array and the accumulation/bias stage. It accepts one operation per cycle.

Parameters:
EXP_W, 8, exponent field width (8 = IEEE single, 5 = half).
MAN_W, 23, stored fraction width (hidden bit not stored).
DATA_W, 1+EXP_W+MAN_W, total word width (derived; do not override).

Ports:
clk  input  1  clock, rising edge
resetn  input  1  synchronous reset, active-low
valid_in  input  1  operands valid this cycle
in_ready  output  1  block can accept operands this cycle
op_sub  input  1  0: in1+in2, 1: in1-in2
in1  input  DATA_W  operand A, {sign, exp, frac}
in2  input  DATA_W  operand B
out_ready  input  1  downstream accepts result
result  output  DATA_W  sum/difference
valid_out  output  1  result valid

Behaviour:
- One clock, clk; reset resetn is synchronous and active-low. At reset: valid_out=0, result=0, all internal stage valids=0; in_ready=1 in the first cycle after reset.
- Transfer in: valid_in && in_ready. Transfer out: valid_out && out_ready.
- Pipeline: 3 register stages, latency 3 cycles from input transfer to valid_out when unstalled. Throughput 1 op/cycle.
  - S1: unpack, flush subnormals, apply op_sub to B sign, compare magnitudes, swap so |A|>=|B|, exponent difference, special-case detect.
  - S2: align smaller mantissa (right shift, guard/round/sticky; shift >= MAN_W+3 leaves sticky only), effective add/sub.
  - S3: normalise (carry-out right shift or leading-zero left shift), round-to-nearest-even, exponent adjust, pack, special-case override.
- Stall: en = out_ready || !valid_out. When en=0 all stages hold, including bubbles. in_ready = en.
- result and valid_out stay stable while valid_out=1 and out_ready=0.
- Bias = 2^(EXP_W-1)-1. Internal mantissa is MAN_W+1 bits plus carry and 3 GRS bits.
- Subnormal inputs (exp=0) are treated as zero with their sign.
- Subnormal or underflowed results flush to signed zero.
- Exact cancellation gives +0. (-0)+(-0) gives -0. (+0)+(-0) gives +0.
- Rounding carry into exponent is handled. Exponent reaching all-ones gives signed infinity.
- Any NaN input, or inf-inf (effective subtract), gives canonical qNaN: sign 0, exp all ones, frac MSB 1, rest 0.
- inf ± finite gives that inf. inf+inf of the same sign gives inf.
- resetn low mid-stream discards all in-flight operations; valid_out=0 on the next edge.
- valid_in while in_ready=0 is ignored. The upstream must hold its operands until the transfer.

Optional Feature:
FP_ADDSUB_FLAGS_EN: when defined, adds output port flags[3:0] = {invalid, overflow, underflow, inexact}. Flags are aligned with result, valid only when valid_out=1, and held under stall.
- invalid: NaN input or inf-inf.
- overflow: finite operands rounded to inf.
- underflow: a nonzero result was flushed to zero.
- inexact: any GRS bit nonzero, or overflow/underflow.
When undefined, the port and its logic are absent; result behaviour is identical.

Test Plan:
- 1.0+2.0: in1=3F800000, in2=40000000, op_sub=0, out_ready=1 -> result=40400000, valid_out exactly 3 cycles later.
- Cancellation: 40400000 minus 40400000 (op_sub=1) -> 00000000. 80000000+80000000 -> 80000000.
- RNE ties: 3F800000+33800000 -> 3F800000. 3F800001+33800000 -> 3F800002 (inexact=1 with flags).
- Specials: 7F7FFFFF+7F7FFFFF -> 7F800000 (overflow=1). 7F800000+FF800000 -> 7FC00000 (invalid=1). 00000001+80000000 -> 00000000.
- Backpressure: 6 back-to-back ops, out_ready=0 for cycles 4-5 -> in_ready=0 during the hold, result held, all 6 results delivered in order with none duplicated or lost.
- Reset/params: assert resetn=0 with 3 ops in flight -> valid_out=0 next cycle and no stale output after release. Rerun the first test with EXP_W=5, MAN_W=10: 3C00+4000 -> 4200.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: parametrised three-stage floating-point adder/subtractor.
//
// Ports:
//   clk        rising-edge clock
//   resetn     synchronous, active-low reset
//   valid_in   operands valid this cycle
//   in_ready   block can accept operands this cycle
//   op_sub     0: in1+in2, 1: in1-in2
//   in1, in2   operands {sign, exp, frac}
//   out_ready  downstream accepts result
//   result     sum/difference
//   valid_out  result valid
//   flags      {invalid, overflow, underflow, inexact}, present only when
//              FP_ADDSUB_FLAGS_EN is defined
//
// Subnormal inputs are treated as signed zero and results that would be
// subnormal are flushed to signed zero. Rounding is round-to-nearest-even.
// The whole pipe advances together on en = out_ready || !valid_out.
module fp_addsub_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int DATA_W = 1 + EXP_W + MAN_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid_in,
  output logic              in_ready,
  input  logic              op_sub,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              valid_out
`ifdef FP_ADDSUB_FLAGS_EN
  ,
  output logic [3:0]        flags
`endif
);

  // Working mantissa: hidden bit + fraction + guard/round/sticky.
  localparam int W       = MAN_W + 4;
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  logic en;
  assign en       = out_ready || !valid_out;
  assign in_ready = en;

  // ---------------- Stage 1: unpack, swap, special detect ----------------
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic [MAN_W:0]   man_a, man_b;
  logic             nan_a, nan_b, inf_a, inf_b;
  logic             c1_sign, c1_nan, c1_inf;
  logic [EXP_W-1:0] c1_exp, c1_diff;
  logic [MAN_W:0]   c1_big, c1_small;

  always_comb begin
    sign_a = in1[DATA_W-1];
    sign_b = in2[DATA_W-1] ^ op_sub;
    exp_a  = in1[DATA_W-2 -: EXP_W];
    exp_b  = in2[DATA_W-2 -: EXP_W];
    frac_a = in1[MAN_W-1:0];
    frac_b = in2[MAN_W-1:0];
    // Zero exponent drops the fraction, so subnormals behave as zero.
    man_a  = (exp_a == '0) ? '0 : {1'b1, frac_a};
    man_b  = (exp_b == '0) ? '0 : {1'b1, frac_b};
    nan_a  = (exp_a == '1) && (frac_a != '0);
    nan_b  = (exp_b == '1) && (frac_b != '0);
    inf_a  = (exp_a == '1) && (frac_a == '0);
    inf_b  = (exp_b == '1) && (frac_b == '0);
    if ({exp_a, man_a} >= {exp_b, man_b}) begin
      c1_sign  = sign_a;
      c1_exp   = exp_a;
      c1_diff  = exp_a - exp_b;
      c1_big   = man_a;
      c1_small = man_b;
    end else begin
      c1_sign  = sign_b;
      c1_exp   = exp_b;
      c1_diff  = exp_b - exp_a;
      c1_big   = man_b;
      c1_small = man_a;
    end
    c1_nan = nan_a | nan_b | (inf_a & inf_b & (sign_a ^ sign_b));
    // After the swap an infinity is always the larger operand, so the
    // result sign c1_sign is also the infinity's sign.
    c1_inf = inf_a | inf_b;
  end

  logic             s1_valid, s1_sign, s1_sub, s1_nan, s1_inf;
  logic [EXP_W-1:0] s1_exp, s1_diff;
  logic [MAN_W:0]   s1_big, s1_small;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_sub   <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_exp   <= '0;
      s1_diff  <= '0;
      s1_big   <= '0;
      s1_small <= '0;
    end else if (en) begin
      s1_valid <= valid_in;
      s1_sign  <= c1_sign;
      s1_sub   <= sign_a ^ sign_b;
      s1_nan   <= c1_nan;
      s1_inf   <= c1_inf;
      s1_exp   <= c1_exp;
      s1_diff  <= c1_diff;
      s1_big   <= c1_big;
      s1_small <= c1_small;
    end
  end

  // ---------------- Stage 2: align and add/subtract ----------------------
  logic [W-1:0] ext_small, shifted, aligned;
  logic         lost;
  logic [W:0]   c2_sum;

  always_comb begin
    ext_small = {s1_small, 3'b000};
    shifted   = ext_small >> s1_diff;
    lost      = |(ext_small & ~({W{1'b1}} << s1_diff));
    // Far shifts keep only a sticky trace of the smaller operand.
    if (int'(s1_diff) >= MAN_W + 3)
      aligned = {{(W-1){1'b0}}, |s1_small};
    else
      aligned = shifted | {{(W-1){1'b0}}, lost};
    // |big| >= |small| after the swap, so subtraction never goes negative.
    if (s1_sub)
      c2_sum = {1'b0, s1_big, 3'b000} - {1'b0, aligned};
    else
      c2_sum = {1'b0, s1_big, 3'b000} + {1'b0, aligned};
  end

  logic             s2_valid, s2_sign, s2_sub, s2_nan, s2_inf;
  logic [EXP_W-1:0] s2_exp;
  logic [W:0]       s2_sum;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_sub   <= 1'b0;
      s2_nan   <= 1'b0;
      s2_inf   <= 1'b0;
      s2_exp   <= '0;
      s2_sum   <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_sub   <= s1_sub;
      s2_nan   <= s1_nan;
      s2_inf   <= s1_inf;
      s2_exp   <= s1_exp;
      s2_sum   <= c2_sum;
    end
  end

  // ---------------- Stage 3: normalise, round, pack ----------------------
  int               lz, exp_n, exp_r;
  logic [W-1:0]     norm;
  logic [MAN_W:0]   mant;
  logic [2:0]       grs;
  logic             round_up, is_zero, ovf, unf;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] frac_r;
  logic [DATA_W-1:0] c3_result;

  always_comb begin
    lz = 0;
    for (int i = 0; i < W; i++)
      if (s2_sum[i]) lz = W - 1 - i;
    // A carry out shifts right by one, folding the dropped bit into sticky.
    if (s2_sum[W]) begin
      norm  = {s2_sum[W:2], |s2_sum[1:0]};
      exp_n = int'(s2_exp) + 1;
    end else begin
      norm  = s2_sum[W-1:0] << lz;
      exp_n = int'(s2_exp) - lz;
    end
    mant     = norm[W-1:3];
    grs      = norm[2:0];
    round_up = grs[2] & (grs[1] | grs[0] | mant[0]);
    mant_r   = {1'b0, mant} + {{(MAN_W+1){1'b0}}, round_up};
    // Rounding 1.11..1 up gives 10.00..0: bump the exponent.
    if (mant_r[MAN_W+1]) begin
      frac_r = mant_r[MAN_W:1];
      exp_r  = exp_n + 1;
    end else begin
      frac_r = mant_r[MAN_W-1:0];
      exp_r  = exp_n;
    end
    is_zero = (s2_sum == '0);
    ovf     = !is_zero && (exp_r >= EXP_MAX);
    unf     = !is_zero && (exp_r <= 0);
    if (s2_nan)
      c3_result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    else if (s2_inf || ovf)
      c3_result = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (is_zero)
      // Exact cancellation is +0; a true add of two zeros keeps their sign.
      c3_result = {s2_sign & !s2_sub, {(DATA_W-1){1'b0}}};
    else if (unf)
      c3_result = {s2_sign, {(DATA_W-1){1'b0}}};
    else
      c3_result = {s2_sign, exp_r[EXP_W-1:0], frac_r};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_out <= 1'b0;
      result    <= '0;
    end else if (en) begin
      valid_out <= s2_valid;
      result    <= c3_result;
    end
  end

`ifdef FP_ADDSUB_FLAGS_EN
  logic [3:0] c3_flags;

  always_comb begin
    c3_flags = 4'b0000;
    if (s2_nan)
      c3_flags = 4'b1000;
    else if (s2_inf || is_zero)
      c3_flags = 4'b0000;
    else if (ovf)
      c3_flags = 4'b0101;
    else if (unf)
      c3_flags = 4'b0011;
    else
      c3_flags = {3'b000, |grs};
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      flags <= 4'b0000;
    else if (en)
      flags <= c3_flags;
  end
`endif

endmodule
